// File: rtl/posit16_conv_arbiter_if.sv
// Bundles the requester, converter and result buses of the posit16 converter arbiter.
interface posit16_conv_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  logic [15:0]           conv_fixed;
  logic [3:0]            conv_regime;
  logic                  conv_exp;
  logic [11:0]           conv_mant;
  logic                  conv_q;
  logic                  conv_sign;

  logic                  res_valid;
  logic                  res_ready;
  logic [ID_W-1:0]       res_id;
  logic [3:0]            res_regime;
  logic                  res_exp;
  logic [11:0]           res_mant;
  logic                  res_q;
  logic                  res_sign;

  // Arbiter view
  modport slave (
    input  req_valid, req_data,
    output req_ready,
    output conv_fixed,
    input  conv_regime, conv_exp, conv_mant, conv_q, conv_sign,
    output res_valid, res_id, res_regime, res_exp, res_mant, res_q, res_sign,
    input  res_ready
  );

  // Producer / converter / consumer view
  modport master (
    output req_valid, req_data,
    input  req_ready,
    input  conv_fixed,
    output conv_regime, conv_exp, conv_mant, conv_q, conv_sign,
    input  res_valid, res_id, res_regime, res_exp, res_mant, res_q, res_sign,
    output res_ready
  );
endinterface

// File: rtl/posit16_conv_arbiter.sv
// Round-robin sharing of one combinational Fixed16toPosit16 converter among
// NUM_REQ requesters, one conversion in flight, tagged registered results.
module posit16_conv_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  posit16_conv_arbiter_if.slave   bus,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_cnt
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned IW1  = ID_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_found;
  logic [IW1-1:0]  cand;
  logic [15:0]     req_word [NUM_REQ];
  logic [15:0]     operand;
  logic            accept;
  logic            res_fire;

  // Split the packed operand bus into per-requester words
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_word[i] = bus.req_data[16*i +: 16];
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW1'(rr_ptr) + IW1'(k);
      if (cand >= IW1'(NUM_REQ)) begin
        cand = cand - IW1'(NUM_REQ);
      end
      if (!gnt_found && bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, grant strobe and result-release strobe
  always_comb begin
    state_n       = state;
    bus.req_ready = '0;
    accept        = 1'b0;
    res_fire      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          bus.req_ready[gnt_idx] = 1'b1;
          accept                 = 1'b1;
          state_n                = CONV;
        end
      end
      CONV: begin
        state_n = HOLD;
      end
      HOLD: begin
        if (bus.res_valid && bus.res_ready) begin
          res_fire = 1'b1;
          state_n  = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Operand capture, result capture/hold, pointer advance and completion count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand        <= '0;
      rr_ptr         <= '0;
      done_cnt       <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_id     <= '0;
      bus.res_regime <= '0;
      bus.res_exp    <= 1'b0;
      bus.res_mant   <= '0;
      bus.res_q      <= 1'b0;
      bus.res_sign   <= 1'b0;
    end else begin
      if (accept) begin
        operand    <= req_word[gnt_idx];
        bus.res_id <= gnt_idx;
      end
      if (state == CONV) begin
        bus.res_regime <= bus.conv_regime;
        bus.res_exp    <= bus.conv_exp;
        bus.res_mant   <= bus.conv_mant;
        bus.res_q      <= bus.conv_q;
        bus.res_sign   <= bus.conv_sign;
        bus.res_valid  <= 1'b1;
      end
      if (res_fire) begin
        bus.res_valid <= 1'b0;
        done_cnt      <= done_cnt + CNT_W'(1);
        rr_ptr        <= (bus.res_id == ID_W'(NUM_REQ - 1)) ? '0 : bus.res_id + ID_W'(1);
      end
    end
  end

  // The shared converter always sees the last accepted operand
  assign bus.conv_fixed = operand;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_posit16_conv_arbiter.sv
// Scoreboard bench for posit16_conv_arbiter with a behavioural Fixed16toPosit16
// converter; a CNT_W=4 instance runs in lockstep to exercise counter wrap.
module tb_posit16_conv_arbiter;

  typedef struct packed {
    logic [3:0]  regime;
    logic        exp;
    logic [11:0] mant;
    logic        q;
    logic        sign;
  } conv_t;

  typedef struct packed {
    logic [1:0] id;
    conv_t      c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy, busy4;
  logic [15:0] done_cnt;
  logic [3:0]  done4;
  conv_t       cv, cv4;
  exp_t        got, got4;
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  posit16_conv_arbiter_if #(.NUM_REQ(4)) ifc ();
  posit16_conv_arbiter_if #(.NUM_REQ(4)) ifc4 ();

  posit16_conv_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave), .busy(busy), .done_cnt(done_cnt)
  );

  posit16_conv_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ifc4.slave), .busy(busy4), .done_cnt(done4)
  );

  // Behavioural converter: value read as Q8.8, scale k = msb-8, regime k>>1, exp k[0]
  function automatic conv_t fx2p(input logic [15:0] x);
    conv_t       r;
    logic [15:0] mag;
    logic [15:0] sh;
    int          p;
    int          k;
    r      = '0;
    r.sign = x[15];
    r.q    = (x == 16'd0);
    mag    = x[15] ? (~x + 16'd1) : x;
    p      = -1;
    for (int i = 0; i < 16; i++) if (mag[i]) p = i;
    if (p >= 0) begin
      k        = p - 8;
      r.regime = 4'(k >>> 1);
      r.exp    = k[0];
      sh       = mag << (16 - p);
      r.mant   = sh[15:4];
    end
    return r;
  endfunction

  function automatic exp_t mk(input int id, input logic [15:0] d);
    exp_t e;
    e.id = 2'(id);
    e.c  = fx2p(d);
    return e;
  endfunction

  always_comb begin
    cv               = fx2p(ifc.conv_fixed);
    ifc.conv_regime  = cv.regime;
    ifc.conv_exp     = cv.exp;
    ifc.conv_mant    = cv.mant;
    ifc.conv_q       = cv.q;
    ifc.conv_sign    = cv.sign;
    cv4              = fx2p(ifc4.conv_fixed);
    ifc4.conv_regime = cv4.regime;
    ifc4.conv_exp    = cv4.exp;
    ifc4.conv_mant   = cv4.mant;
    ifc4.conv_q      = cv4.q;
    ifc4.conv_sign   = cv4.sign;
  end

  assign ifc4.req_valid = ifc.req_valid;
  assign ifc4.req_data  = ifc.req_data;
  assign ifc4.res_ready = ifc.res_ready;

  assign got  = {ifc.res_id, ifc.res_regime, ifc.res_exp, ifc.res_mant, ifc.res_q, ifc.res_sign};
  assign got4 = {ifc4.res_id, ifc4.res_regime, ifc4.res_exp, ifc4.res_mant, ifc4.res_q, ifc4.res_sign};

  task automatic do_reset;
    @(negedge clk);
    ifc.req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    ifc.req_valid = '0;
    ifc.req_data  = '0;
    ifc.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({ifc.res_valid, busy, ifc.req_ready, done_cnt, ifc.conv_fixed, got, done4} !== '0) begin
      fails++;
      $display("FAIL reset_state got %h want 0",
               {ifc.res_valid, busy, ifc.req_ready, done_cnt, ifc.conv_fixed, got, done4});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    exp_t e;
    @(negedge clk);
    ifc.res_ready       = 1'b1;
    ifc.req_data[15:0]  = 16'h4000;
    ifc.req_valid       = 4'b0001;
    sb.push_back(mk(0, 16'h4000));
    #1;
    tests++;
    if (ifc.req_ready !== 4'b0001) begin
      fails++; $display("FAIL single_grant got %b want 0001", ifc.req_ready);
    end
    @(negedge clk);
    ifc.req_valid = '0;
    tests++;
    if ({ifc.res_valid, busy, ifc.conv_fixed, ifc.req_ready} !== {1'b0, 1'b1, 16'h4000, 4'b0000}) begin
      fails++; $display("FAIL single_conv got %h want %h",
                        {ifc.res_valid, busy, ifc.conv_fixed, ifc.req_ready}, {1'b0, 1'b1, 16'h4000, 4'b0000});
    end
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if ({ifc.res_valid, got} !== {1'b1, e}) begin
      fails++; $display("FAIL single_result got %h want %h", {ifc.res_valid, got}, {1'b1, e});
    end
    @(negedge clk);
    tests++;
    if ({ifc.res_valid, busy, done_cnt} !== {1'b0, 1'b0, 16'd1}) begin
      fails++; $display("FAIL single_release got %h want %h", {ifc.res_valid, busy, done_cnt}, {1'b0, 1'b0, 16'd1});
    end
  endtask

  task automatic test_round_robin;
    int          order [5] = '{0, 1, 2, 3, 0};
    logic [15:0] d [4] = '{16'h0180, 16'hFE00, 16'h7FFF, 16'h0003};
    logic [3:0]  oh;
    exp_t        e;
    int          n_res = 0, n_gnt = 0, last = 0, cyc = 0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) ifc.req_data[16*i +: 16] = d[i];
    ifc.res_ready = 1'b1;
    ifc.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) sb.push_back(mk(order[i], d[order[i]]));
    #1;
    while (n_res < 5 && cyc < 60) begin
      if (ifc.req_ready != 4'b0000) begin
        oh = 4'b0001 << order[n_gnt < 5 ? n_gnt : 4];
        tests++;
        if (ifc.req_ready !== oh) begin
          fails++; $display("FAIL rr_grant%0d got %b want %b", n_gnt, ifc.req_ready, oh);
        end
        if (n_gnt > 0) begin
          tests++;
          if (cyc - last != 3) begin
            fails++; $display("FAIL rr_interval%0d got %0d want 3", n_gnt, cyc - last);
          end
        end
        last = cyc;
        n_gnt++;
      end
      if (ifc.res_valid) begin
        e = sb.pop_front();
        tests++;
        if (got !== e) begin
          fails++; $display("FAIL rr_result%0d got %h want %h", n_res, got, e);
        end
        n_res++;
      end
      @(negedge clk);
      cyc++;
    end
    ifc.req_valid = '0;
    tests++;
    if (n_res != 5) begin
      fails++; $display("FAIL rr_timeout got %0d results want 5", n_res);
    end
    tests++;
    if (done_cnt !== 16'd5) begin
      fails++; $display("FAIL rr_done_cnt got %0d want 5", done_cnt);
    end
  endtask

  task automatic test_backpressure;
    exp_t e, e_hold;
    @(negedge clk);
    ifc.res_ready           = 1'b0;
    ifc.req_data[63:48]     = 16'h1234;
    ifc.req_valid           = 4'b1000;
    sb.push_back(mk(3, 16'h1234));
    #1;
    tests++;
    if (ifc.req_ready !== 4'b1000) begin
      fails++; $display("FAIL bp_grant got %b want 1000", ifc.req_ready);
    end
    @(negedge clk);
    ifc.req_data[31:16] = 16'hF00D;
    ifc.req_valid       = 4'b0010;
    @(negedge clk);
    e_hold = sb.pop_front();
    tests++;
    if ({ifc.res_valid, got} !== {1'b1, e_hold}) begin
      fails++; $display("FAIL bp_result got %h want %h", {ifc.res_valid, got}, {1'b1, e_hold});
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({ifc.res_valid, ifc.req_ready, got} !== {1'b1, 4'b0000, e_hold}) begin
        fails++; $display("FAIL bp_hold%0d got %h want %h", i, {ifc.res_valid, ifc.req_ready, got},
                          {1'b1, 4'b0000, e_hold});
      end
    end
    ifc.res_ready = 1'b1;
    sb.push_back(mk(1, 16'hF00D));
    @(negedge clk);
    tests++;
    if ({ifc.res_valid, ifc.req_ready, done_cnt} !== {1'b0, 4'b0010, 16'd6}) begin
      fails++; $display("FAIL bp_release got %h want %h", {ifc.res_valid, ifc.req_ready, done_cnt},
                        {1'b0, 4'b0010, 16'd6});
    end
    @(negedge clk);
    ifc.req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if ({ifc.res_valid, got} !== {1'b1, e}) begin
      fails++; $display("FAIL bp_next_result got %h want %h", {ifc.res_valid, got}, {1'b1, e});
    end
    @(negedge clk);
  endtask

  task automatic test_signs;
    logic [15:0] d [2] = '{16'hC000, 16'h0000};
    int          id [2] = '{2, 1};
    conv_t       z;
    exp_t        e;
    z = fx2p(16'h0000);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      ifc.res_ready = 1'b1;
      ifc.req_data[16*id[n] +: 16] = d[n];
      ifc.req_valid = 4'b0001 << id[n];
      sb.push_back(mk(id[n], d[n]));
      #1;
      tests++;
      if (ifc.req_ready !== (4'b0001 << id[n])) begin
        fails++; $display("FAIL sign_grant%0d got %b want %b", n, ifc.req_ready, 4'b0001 << id[n]);
      end
      @(negedge clk);
      ifc.req_valid = '0;
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({ifc.res_valid, got} !== {1'b1, e}) begin
        fails++; $display("FAIL sign_result%0d got %h want %h", n, {ifc.res_valid, got}, {1'b1, e});
      end
      tests++;
      if (n == 0 && ifc.res_sign !== 1'b1) begin
        fails++; $display("FAIL sign_neg got %b want 1", ifc.res_sign);
      end else if (n == 1 && {ifc.res_sign, ifc.res_q} !== {1'b0, z.q}) begin
        fails++; $display("FAIL sign_zero got %b want %b", {ifc.res_sign, ifc.res_q}, {1'b0, z.q});
      end
      @(negedge clk);
    end
    tests++;
    if (done_cnt !== 16'd9) begin
      fails++; $display("FAIL sign_done_cnt got %0d want 9", done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    @(negedge clk);
    ifc.req_data[63:48] = 16'h0777;
    ifc.req_valid       = 4'b1000;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || ifc.res_valid !== 1'b0) begin
      fails++; $display("FAIL mid_in_conv got %b want 10", {busy, ifc.res_valid});
    end
    ifc.req_valid = '0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ifc.res_valid, busy, done_cnt, ifc.req_ready, ifc.conv_fixed, done4} !== '0) begin
      fails++; $display("FAIL mid_reset got %h want 0",
                        {ifc.res_valid, busy, done_cnt, ifc.req_ready, ifc.conv_fixed, done4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (ifc.res_valid !== 1'b0) begin
      fails++; $display("FAIL mid_no_result got %b want 0", ifc.res_valid);
    end
    ifc.req_data[31:16] = 16'h0040;
    ifc.req_data[63:48] = 16'h2000;
    ifc.req_valid       = 4'b1010;
    sb.push_back(mk(1, 16'h0040));
    #1;
    tests++;
    if (ifc.req_ready !== 4'b0010) begin
      fails++; $display("FAIL mid_regrant got %b want 0010", ifc.req_ready);
    end
    @(negedge clk);
    ifc.req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if ({ifc.res_valid, got} !== {1'b1, e}) begin
      fails++; $display("FAIL mid_result got %h want %h", {ifc.res_valid, got}, {1'b1, e});
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    exp_t        e;
    int          id;
    logic [15:0] d;
    do_reset();
    ifc.res_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      id = k % 4;
      d  = 16'($urandom);
      @(negedge clk);
      ifc.req_data[16*id +: 16] = d;
      ifc.req_valid = 4'b0001 << id;
      sb.push_back(mk(id, d));
      #1;
      tests++;
      if (ifc.req_ready !== (4'b0001 << id)) begin
        fails++; $display("FAIL wrap_grant%0d got %b want %b", k, ifc.req_ready, 4'b0001 << id);
      end
      @(negedge clk);
      ifc.req_valid = '0;
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({ifc.res_valid, got, got4} !== {1'b1, e, e}) begin
        fails++; $display("FAIL wrap_result%0d got %h want %h", k, {ifc.res_valid, got, got4}, {1'b1, e, e});
      end
      @(negedge clk);
      tests++;
      if ({done4, done_cnt} !== {4'(k + 1), 16'(k + 1)}) begin
        fails++; $display("FAIL wrap_count%0d got %h want %h", k, {done4, done_cnt}, {4'(k + 1), 16'(k + 1)});
      end
    end
    tests++;
    if (done4 !== 4'd1) begin
      fails++; $display("FAIL wrap_final got %0d want 1", done4);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_signs();
    test_reset_mid();
    test_wrap();
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
